bcd_display_scanner: RTL and testbench

Parametrised, time-multiplexed multi-digit BCD 7-segment display driver. It is the next generation of our single-digit BCD-to-segment decoder and sits between the BCD adder/multiplier result registers and the board's common-anode/cathode display. It adds:
- N-digit scanning with a one-cycle anti-ghost gap
- decimal points
- leading-zero blanking
- invalid-digit indication
- a valid/ready load port that updates the display atomically at frame boundaries

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/bcd_seg7_decode.sv | 11 +
 rtl/bcd_display_scanner.sv | 168 ++++++++++++++++
 tb/tb_bcd_display_scanner.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, BCD-to-segment mapping and scanner state type.
// Segment vectors are ordered {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } state_t;

    // Non-BCD nibbles render as a dash so bad data is visible on the glass.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        case (nib)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// Combinational BCD nibble to 7-segment pattern decoder.
module bcd_seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = bcd_to_seg(i_nib);

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed N-digit BCD 7-segment driver with frame-atomic loads,
// leading-zero blanking, anti-ghost gap and sticky invalid-digit flag.
module bcd_display_scanner
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV            = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic [DIGITS-1:0]     load_dp,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  bad_digit
);

    localparam int PRE_W = $clog2(DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_t                r_state;
    logic [PRE_W-1:0]      r_pre;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_pending;
    logic                  r_bad;
    logic [4*DIGITS-1:0]   r_disp;
    logic [DIGITS-1:0]     r_dp;
    logic [4*DIGITS-1:0]   r_shadow;
    logic [DIGITS-1:0]     r_shadow_dp;

    logic [6:0]            r_seg_p1;
    logic                  r_dp_p1;
    logic [DIGITS-1:0]     r_an_p1;
    logic                  r_fd_p1;

    logic                  w_accept;
    logic                  w_pre_last;
    logic                  w_boundary;
    logic                  w_disp_we;
    logic                  w_shadow_we;
    logic [4*DIGITS-1:0]   w_disp_nxt;
    logic [DIGITS-1:0]     w_dp_nxt;
    logic [DIGITS-1:0]     w_lz;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg_dec;

    function automatic logic has_bad(input logic [4*DIGITS-1:0] v);
        has_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) has_bad = 1'b1;
        end
    endfunction

    assign load_ready  = !r_pending;
    assign w_accept    = load_valid && !r_pending;
    assign w_pre_last  = (r_pre == PRE_LAST);
    assign w_boundary  = (r_state == SCAN) && w_pre_last && (r_idx == IDX_LAST);
    assign w_shadow_we = (r_state == SCAN) && !w_boundary && w_accept;

    // Display register source: direct load from BLANK, shadow or bypass at a frame boundary.
    always_comb begin
        w_disp_we  = 1'b0;
        w_disp_nxt = load_data;
        w_dp_nxt   = load_dp;
        if (r_state == BLANK) begin
            w_disp_we = w_accept;
        end else if (w_boundary) begin
            if (r_pending) begin
                w_disp_we  = 1'b1;
                w_disp_nxt = r_shadow;
                w_dp_nxt   = r_shadow_dp;
            end else begin
                w_disp_we = w_accept;
            end
        end
    end

    // Digit i is blanked when it and every more-significant nibble are zero.
    always_comb begin
        logic v_zero;
        w_lz   = '0;
        v_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            v_zero  = v_zero && (r_disp[4*i +: 4] == 4'd0);
            w_lz[i] = blank_lz && v_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= BLANK;
            r_pre     <= '0;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            if (w_disp_we && has_bad(w_disp_nxt)) r_bad <= 1'b1;
            if (r_state == BLANK) begin
                r_pre <= '0;
                r_idx <= '0;
                if (w_accept) r_state <= SCAN;
            end else begin
                if (w_pre_last) begin
                    r_pre <= '0;
                    r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
                if (w_boundary)       r_pending <= 1'b0;
                else if (w_shadow_we) r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_disp_we) begin
            r_disp <= w_disp_nxt;
            r_dp   <= w_dp_nxt;
        end
        if (w_shadow_we) begin
            r_shadow    <= load_data;
            r_shadow_dp <= load_dp;
        end
    end

    assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

    bcd_seg7_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg_dec)
    );

    // Stage p1: registered pin drive; an is held off on the first cycle of each slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_p1 <= SEG_OFF;
            r_dp_p1  <= 1'b0;
            r_an_p1  <= '0;
            r_fd_p1  <= 1'b0;
        end else if (r_state == BLANK) begin
            r_seg_p1 <= SEG_OFF;
            r_dp_p1  <= 1'b0;
            r_an_p1  <= '0;
            r_fd_p1  <= 1'b0;
        end else begin
            r_seg_p1 <= w_lz[r_idx] ? SEG_OFF : w_seg_dec;
            r_dp_p1  <= r_dp[r_idx];
            r_an_p1  <= ((r_pre == '0) || w_lz[r_idx]) ? '0 : (DIGITS'(1) << r_idx);
            r_fd_p1  <= w_boundary;
        end
    end

    assign seg        = SEG_ACTIVE_LOW ? ~r_seg_p1 : r_seg_p1;
    assign dp         = SEG_ACTIVE_LOW ? ~r_dp_p1  : r_dp_p1;
    assign an         = AN_ACTIVE_LOW  ? ~r_an_p1  : r_an_p1;
    assign frame_done = r_fd_p1;
    assign bad_digit  = r_bad;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomised and directed bench for bcd_display_scanner against a time-based
// behavioural model (slot/position derived from cycles since the load).
module tb_bcd_display_scanner;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;
    localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic [3:0]  load_dp = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;
    logic        bad_digit;

    int errors = 0;
    int checks = 0;

    bit          m_scan, m_pend, m_bad;
    int          m_t;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_dp, m_shadow_dp;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;
    logic [3:0]  e_an;
    bit          e_seg_care;
    logic [14:0] got, exp;

    bcd_display_scanner #(
        .DIGITS(DIGITS), .DIV(DIV), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_dp(load_dp), .blank_lz(blank_lz),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done), .bad_digit(bad_digit)
    );

    always #5 clk = ~clk;

    function automatic bit any_bad(input logic [15:0] v);
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) any_bad = 1'b1;
    endfunction

    task automatic model_reset();
        m_scan = 0; m_pend = 0; m_bad = 0; m_t = 0;
        e_seg = 7'h00; e_dp = 1'b0; e_fd = 1'b0; e_an = 4'b0000; e_seg_care = 1;
    endtask

    // Advance one clock and update the expected pin values from the model.
    task automatic step();
        bit acc, blanked;
        int slot, pos;
        @(posedge clk);
        acc = load_valid && !m_pend;
        if (rst) begin
            model_reset();
        end else if (!m_scan) begin
            e_seg = 7'h00; e_dp = 1'b0; e_fd = 1'b0; e_an = 4'b0000; e_seg_care = 1;
            if (acc) begin
                m_disp = load_data; m_dp = load_dp; m_scan = 1; m_t = 0;
                if (any_bad(load_data)) m_bad = 1;
            end
        end else begin
            slot    = m_t / DIV;
            pos     = m_t % DIV;
            blanked = blank_lz && (slot > 0) && ((m_disp >> (4*slot)) == 16'h0);
            e_an       = (pos == 0 || blanked) ? 4'b0000 : 4'(1 << slot);
            e_seg      = blanked ? 7'h00 : SEG_TAB[m_disp[4*slot +: 4]];
            e_seg_care = blanked || (pos != 0);
            e_dp       = m_dp[slot];
            e_fd       = (m_t == FRAME - 1);
            if (e_fd) begin
                if (m_pend) begin
                    m_disp = m_shadow; m_dp = m_shadow_dp; m_pend = 0;
                    if (any_bad(m_shadow)) m_bad = 1;
                end else if (acc) begin
                    m_disp = load_data; m_dp = load_dp;
                    if (any_bad(load_data)) m_bad = 1;
                end
            end else if (acc) begin
                m_shadow = load_data; m_shadow_dp = load_dp; m_pend = 1;
            end
            m_t = (m_t + 1) % FRAME;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; load_valid = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (20) begin
            step();
            got = {an, seg, dp, frame_done, load_ready, bad_digit};
            exp = {4'b0000, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_idle: got %h expected %h", got, exp); end
        end
    endtask

    task automatic test_scan_digits();
        int cyc = 0, last_fd = -1;
        do_reset();
        blank_lz = 0; load_data = 16'h1234; load_dp = 4'b0000; load_valid = 1;
        step();
        load_valid = 0;
        repeat (3 * FRAME) begin
            step(); cyc++;
            got = {an, e_seg_care ? seg : 7'h0, dp, frame_done, load_ready, bad_digit};
            exp = {e_an, e_seg_care ? e_seg : 7'h0, e_dp, e_fd, !m_pend, m_bad};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL scan_1234 cyc %0d: got %h expected %h", cyc, got, exp); end
            if (frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (cyc - last_fd != FRAME) begin
                        errors++; $display("FAIL frame_period: got %0d expected %0d", cyc - last_fd, FRAME);
                    end
                end
                last_fd = cyc;
            end
        end
        checks++;
        if (last_fd < 0) begin errors++; $display("FAIL frame_done_seen: got 0 expected 1"); end
    endtask

    task automatic test_blanking();
        int hi_lit = 0;
        do_reset();
        blank_lz = 1; load_data = 16'h0050; load_dp = 4'b0100; load_valid = 1;
        step();
        load_valid = 0;
        repeat (2 * FRAME) begin
            step();
            if (an[3:2] != 2'b00) hi_lit++;
            got = {an, e_seg_care ? seg : 7'h0, dp, frame_done, load_ready, bad_digit};
            exp = {e_an, e_seg_care ? e_seg : 7'h0, e_dp, e_fd, !m_pend, m_bad};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL blank_lz_on: got %h expected %h", got, exp); end
        end
        checks++;
        if (hi_lit != 0) begin errors++; $display("FAIL blank_hi_digits: got %0d lit cycles expected 0", hi_lit); end
        blank_lz = 0;
        repeat (FRAME) begin
            step();
            got = {an, e_seg_care ? seg : 7'h0, dp, frame_done, load_ready, bad_digit};
            exp = {e_an, e_seg_care ? e_seg : 7'h0, e_dp, e_fd, !m_pend, m_bad};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL blank_lz_off: got %h expected %h", got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        blank_lz = 0; load_data = 16'h1234; load_dp = 4'b0000; load_valid = 1;
        step();
        load_valid = 0;
        repeat (5) step();
        load_data = 16'h9999; load_dp = 4'b0001; load_valid = 1;
        step();
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL ready_after_load: got %b expected 0", load_ready); end
        load_data = 16'h5555;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k == 3) load_valid = 0;
            step();
            got = {an, e_seg_care ? seg : 7'h0, dp, frame_done, load_ready, bad_digit};
            exp = {e_an, e_seg_care ? e_seg : 7'h0, e_dp, e_fd, !m_pend, m_bad};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL back_to_back k=%0d: got %h expected %h", k, got, exp); end
            if (k >= FRAME && an !== 4'b0000) begin
                checks++;
                if (seg !== 7'h6F) begin errors++; $display("FAIL new_frame_seg: got %h expected 6f", seg); end
            end
        end
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL ready_restored: got %b expected 1", load_ready); end
    endtask

    task automatic test_bad_digit();
        do_reset();
        blank_lz = 0; load_data = 16'h00A3; load_dp = 4'b0000; load_valid = 1;
        step();
        load_valid = 0;
        repeat (FRAME + 3) begin
            step();
            got = {an, e_seg_care ? seg : 7'h0, dp, frame_done, load_ready, bad_digit};
            exp = {e_an, e_seg_care ? e_seg : 7'h0, e_dp, e_fd, !m_pend, m_bad};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL bad_a3: got %h expected %h", got, exp); end
        end
        checks++;
        if (bad_digit !== 1'b1) begin errors++; $display("FAIL bad_set: got %b expected 1", bad_digit); end
        load_data = 16'h0001; load_valid = 1;
        step();
        load_valid = 0;
        repeat (2 * FRAME) step();
        checks++;
        if (bad_digit !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %b expected 1", bad_digit); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_data = 16'h1234; load_dp = 4'b1111; load_valid = 1;
        step();
        load_valid = 0;
        repeat (6) step();
        load_data = 16'h9999; load_valid = 1;
        step();
        load_valid = 0;
        step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        got = {an, seg, dp, frame_done, load_ready, bad_digit};
        exp = {4'b0000, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL async_reset: got %h expected %h", got, exp); end
        step();
        rst = 1'b0;
        repeat (20) begin
            step();
            got = {an, seg, dp, frame_done, load_ready, bad_digit};
            exp = {e_an, e_seg, e_dp, e_fd, !m_pend, m_bad};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL post_reset_blank: got %h expected %h", got, exp); end
        end
    endtask

    task automatic test_random();
        int nd;
        do_reset();
        repeat (600) begin
            load_valid = ($urandom_range(0, 5) == 0);
            nd = $urandom_range(0, DIGITS);
            load_data = '0;
            for (int i = 0; i < nd; i++)
                load_data[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                                   : 4'($urandom_range(0, 9));
            load_dp = 4'($urandom);
            if ($urandom_range(0, 30) == 0) blank_lz = ~blank_lz;
            step();
            got = {an, e_seg_care ? seg : 7'h0, dp, frame_done, load_ready, bad_digit};
            exp = {e_an, e_seg_care ? e_seg : 7'h0, e_dp, e_fd, !m_pend, m_bad};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random: got %h expected %h", got, exp); end
        end
        load_valid = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan_digits();
        test_blanking();
        test_back_to_back();
        test_bad_digit();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
